// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   state_t   : controller FSM states (RUN, LDSTALL, DWAIT)
//   regbits_t : register-address type at the default width
//   ZERO_REG  : hard-wired zero register, never a hazard source
//   LD_CNT_W  : width of the load-use bubble counter (LOAD_LAT <= 3)
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      LDSTALL = 2'd1,
      DWAIT   = 2'd2
   } state_t;

   localparam int DEF_REG_W = 5;
   typedef logic [DEF_REG_W-1:0] regbits_t;

   localparam int ZERO_REG = 0;
   localparam int LD_CNT_W = 2;

endpackage

// File: rtl/hazard_match.sv
// Combinational source-operand matcher.
// Compares NUM_SRC packed decode-stage source registers against the
// EX-stage destination; the zero register never produces a hit.
//   i_src_reg : NUM_SRC*REG_W packed sources, source 0 in the LSBs
//   i_wsel    : EX-stage destination register
//   o_hit     : 1 when any source equals a non-zero destination
module hazard_match
   import hazard_pkg::*;
#(
   parameter int REG_W   = 5,
   parameter int NUM_SRC = 2
) (
   input  logic [NUM_SRC*REG_W-1:0] i_src_reg,
   input  logic [REG_W-1:0]         i_wsel,
   output logic                     o_hit
);

   logic w_any;

   always_comb begin
      w_any = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (i_src_reg[i*REG_W +: REG_W] == i_wsel) begin
            w_any = 1'b1;
         end
      end
   end

   assign o_hit = w_any && (i_wsel != REG_W'(ZERO_REG));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: detects data-memory wait, control redirect,
// load-use and instruction-fetch miss, and drives the PC enable plus the
// enable/flush pair of every pipeline latch. Priority, highest first:
// dwait > redirect > load-use > imiss.
//   CLK, nRST            : clock, synchronous active-low reset
//   ihit, dhit           : fetch / data access complete this cycle
//   dmemREN, dmemWEN     : load / store in MEM
//   src_reg, ex_wsel     : decode sources, EX destination
//   ex_memREN            : EX instruction is a load
//   redirect             : control redirect resolved at BR_STAGE
//   pc_en, *_en, *_flush : PC and latch controls (flush wins over en)
//   stall_cycles         : saturating count of cycles with pc_en=0
//   o_dbg_state/ld_cnt   : FSM state and pending bubble count
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_W       = 5,
   parameter int NUM_SRC     = 2,
   parameter int LOAD_LAT    = 1,
   parameter int BR_STAGE    = 1,
   parameter int STALL_CNT_W = 16
) (
   input  logic                     CLK,
   input  logic                     nRST,
   input  logic                     ihit,
   input  logic                     dhit,
   input  logic                     dmemREN,
   input  logic                     dmemWEN,
   input  logic [NUM_SRC*REG_W-1:0] src_reg,
   input  logic [REG_W-1:0]         ex_wsel,
   input  logic                     ex_memREN,
   input  logic                     redirect,
   output logic                     pc_en,
   output logic                     ifid_en,
   output logic                     idex_en,
   output logic                     exmem_en,
   output logic                     memwb_en,
   output logic                     ifid_flush,
   output logic                     idex_flush,
   output logic                     exmem_flush,
   output logic                     memwb_flush,
   output logic [STALL_CNT_W-1:0]   stall_cycles,
   output state_t                   o_dbg_state,
   output logic [LD_CNT_W-1:0]      o_dbg_ld_cnt
);

   state_t                  r_state;
   state_t                  w_state_nxt;
   state_t                  w_eff_state;
   logic [LD_CNT_W-1:0]     r_ld_cnt;
   logic [LD_CNT_W-1:0]     w_ld_cnt_nxt;
   logic [STALL_CNT_W-1:0]  r_stall;
   logic                    w_match;
   logic                    w_load_use;
   logic                    w_dwait;

   hazard_match #(
      .REG_W   (REG_W),
      .NUM_SRC (NUM_SRC)
   ) u_match (
      .i_src_reg (src_reg),
      .i_wsel    (ex_wsel),
      .o_hit     (w_match)
   );

   assign w_dwait    = (dmemREN | dmemWEN) & ~dhit;
   assign w_load_use = ex_memREN & w_match;

   always_comb begin
      pc_en        = 1'b1;
      ifid_en      = 1'b1;
      idex_en      = 1'b1;
      exmem_en     = 1'b1;
      memwb_en     = 1'b1;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      exmem_flush  = 1'b0;
      memwb_flush  = 1'b0;
      w_state_nxt  = r_state;
      w_ld_cnt_nxt = r_ld_cnt;
      // The dhit cycle that ends a data wait is evaluated as the state the
      // wait interrupted: LDSTALL if bubbles are still owed, else RUN.
      if (r_state == DWAIT) begin
         w_eff_state = (r_ld_cnt != '0) ? LDSTALL : RUN;
      end else begin
         w_eff_state = r_state;
      end

      if (!nRST) begin
         pc_en        = 1'b0;
         ifid_en      = 1'b0;
         idex_en      = 1'b0;
         exmem_en     = 1'b0;
         memwb_en     = 1'b0;
         w_state_nxt  = RUN;
         w_ld_cnt_nxt = '0;
      end else if (w_dwait) begin
         // Whole pipe frozen; bubble count held until the access completes.
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_en     = 1'b0;
         exmem_en    = 1'b0;
         memwb_en    = 1'b0;
         w_state_nxt = DWAIT;
      end else if (redirect) begin
         // The instruction that owned any pending load-use is squashed.
         w_state_nxt  = RUN;
         w_ld_cnt_nxt = '0;
         if (ihit) begin
            ifid_flush = 1'b1;
            idex_flush = (BR_STAGE == 2);
         end else if (BR_STAGE == 1) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
         end else begin
            // Redirect resolved in EX must be held there until the fetch lands.
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
         end
      end else if (w_eff_state == LDSTALL) begin
         pc_en        = 1'b0;
         ifid_en      = 1'b0;
         idex_flush   = 1'b1;
         w_ld_cnt_nxt = r_ld_cnt - LD_CNT_W'(1);
         w_state_nxt  = (r_ld_cnt == LD_CNT_W'(1)) ? RUN : LDSTALL;
      end else if (w_load_use) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
         if (LOAD_LAT > 1) begin
            w_ld_cnt_nxt = LD_CNT_W'(LOAD_LAT - 1);
            w_state_nxt  = LDSTALL;
         end else begin
            w_state_nxt = RUN;
         end
      end else begin
         w_state_nxt = RUN;
         if (!ihit) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_state  <= RUN;
         r_ld_cnt <= '0;
         r_stall  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_ld_cnt <= w_ld_cnt_nxt;
         if (!pc_en && (r_stall != '1)) begin
            r_stall <= r_stall + STALL_CNT_W'(1);
         end
      end
   end

   assign stall_cycles = r_stall;
   assign o_dbg_state  = r_state;
   assign o_dbg_ld_cnt = r_ld_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Two instances share stimulus:
//   dut_a : LOAD_LAT=2, BR_STAGE=2, STALL_CNT_W=16
//   dut_b : LOAD_LAT=1, BR_STAGE=1, STALL_CNT_W=4
// Inputs change just after the falling edge; outputs are checked 1 ns later.
// Output vector bits: {pc,ifid_en,idex_en,exmem_en,memwb_en,
//                      ifid_fl,idex_fl,exmem_fl,memwb_fl}
module tb_pipeline_hazard_ctrl;
   import hazard_pkg::*;

   localparam logic [8:0] O_NORM = 9'b111110000;
   localparam logic [8:0] O_ZERO = 9'b000000000;
   localparam logic [8:0] O_BUB  = 9'b001110100;
   localparam logic [8:0] O_RH1  = 9'b111111000;
   localparam logic [8:0] O_RH2  = 9'b111111100;
   localparam logic [8:0] M_ALL  = 9'b111111111;
   localparam logic [8:0] M_BUB  = 9'b110111111; // idex_en is don't-care under flush

   logic        clk = 1'b0;
   logic        nrst;
   logic        ihit, dhit, dmem_ren, dmem_wen, ex_mem_ren, redirect;
   logic [9:0]  src_reg;
   logic [4:0]  ex_wsel;

   logic        a_pc, a_ife, a_ide, a_exe, a_mwe, a_iff, a_idf, a_exf, a_mwf;
   logic        b_pc, b_ife, b_ide, b_exe, b_mwe, b_iff, b_idf, b_exf, b_mwf;
   logic [15:0] a_stall;
   logic [3:0]  b_stall;
   state_t      a_state, b_state;
   logic [1:0]  a_ld, b_ld;
   logic [8:0]  a_out, b_out;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign a_out = {a_pc, a_ife, a_ide, a_exe, a_mwe, a_iff, a_idf, a_exf, a_mwf};
   assign b_out = {b_pc, b_ife, b_ide, b_exe, b_mwe, b_iff, b_idf, b_exf, b_mwf};

   pipeline_hazard_ctrl #(
      .REG_W(5), .NUM_SRC(2), .LOAD_LAT(2), .BR_STAGE(2), .STALL_CNT_W(16)
   ) dut_a (
      .CLK(clk), .nRST(nrst), .ihit(ihit), .dhit(dhit),
      .dmemREN(dmem_ren), .dmemWEN(dmem_wen), .src_reg(src_reg),
      .ex_wsel(ex_wsel), .ex_memREN(ex_mem_ren), .redirect(redirect),
      .pc_en(a_pc), .ifid_en(a_ife), .idex_en(a_ide), .exmem_en(a_exe),
      .memwb_en(a_mwe), .ifid_flush(a_iff), .idex_flush(a_idf),
      .exmem_flush(a_exf), .memwb_flush(a_mwf), .stall_cycles(a_stall),
      .o_dbg_state(a_state), .o_dbg_ld_cnt(a_ld)
   );

   pipeline_hazard_ctrl #(
      .REG_W(5), .NUM_SRC(2), .LOAD_LAT(1), .BR_STAGE(1), .STALL_CNT_W(4)
   ) dut_b (
      .CLK(clk), .nRST(nrst), .ihit(ihit), .dhit(dhit),
      .dmemREN(dmem_ren), .dmemWEN(dmem_wen), .src_reg(src_reg),
      .ex_wsel(ex_wsel), .ex_memREN(ex_mem_ren), .redirect(redirect),
      .pc_en(b_pc), .ifid_en(b_ife), .idex_en(b_ide), .exmem_en(b_exe),
      .memwb_en(b_mwe), .ifid_flush(b_iff), .idex_flush(b_idf),
      .exmem_flush(b_exf), .memwb_flush(b_mwf), .stall_cycles(b_stall),
      .o_dbg_state(b_state), .o_dbg_ld_cnt(b_ld)
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [8:0] got,
                          input logic [8:0] exp, input logic [8:0] mask);
      n_cmp++;
      assert ((got & mask) === (exp & mask)) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b (mask %b)", tag, got, exp, mask);
      end
   endtask

   task automatic idle();
      ihit = 1'b1; dhit = 1'b1; dmem_ren = 1'b0; dmem_wen = 1'b0;
      ex_mem_ren = 1'b0; ex_wsel = 5'd0; src_reg = 10'd0; redirect = 1'b0;
   endtask

   task automatic load_use(input logic [4:0] wsel);
      idle();
      ex_mem_ren = 1'b1; ex_wsel = wsel; src_reg = {5'd9, 5'd8};
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk_stall(input string tag, input logic [15:0] ea, input logic [15:0] eb);
      chk({tag, "_sa"}, a_stall, ea);
      chk({tag, "_sb"}, {12'd0, b_stall}, eb);
   endtask

   initial begin
      nrst = 1'b0;
      idle();

      // Reset held two cycles with ihit=1
      step(); #1;
      chk_out("rst1_a", a_out, O_ZERO, M_ALL);
      chk_out("rst1_b", b_out, O_ZERO, M_ALL);
      chk_stall("rst1", 16'd0, 16'd0);
      chk("rst1_st", {14'd0, a_state}, {14'd0, RUN});
      step(); #1;
      chk_out("rst2_a", a_out, O_ZERO, M_ALL);
      chk_out("rst2_b", b_out, O_ZERO, M_ALL);
      step(); nrst = 1'b1; #1;
      chk_out("rel_a", a_out, O_NORM, M_ALL);
      chk_out("rel_b", b_out, O_NORM, M_ALL);
      chk_stall("rel", 16'd0, 16'd0);

      // Load-use on source 0 (ex_wsel=8, src={9,8})
      step(); load_use(5'd8); #1;
      chk_out("lu1_a", a_out, O_BUB, M_BUB);
      chk_out("lu1_b", b_out, O_BUB, M_BUB);
      step(); idle(); #1;
      chk_out("lu2_a", a_out, O_BUB, M_BUB);
      chk("lu2_st", {14'd0, a_state}, {14'd0, LDSTALL});
      chk("lu2_ld", {14'd0, a_ld}, 16'd1);
      chk_out("lu2_b", b_out, O_NORM, M_ALL);
      chk_stall("lu2", 16'd1, 16'd1);
      step(); idle(); #1;
      chk_out("lu3_a", a_out, O_NORM, M_ALL);
      chk("lu3_st", {14'd0, a_state}, {14'd0, RUN});
      chk_stall("lu3", 16'd2, 16'd1);

      // Register 0 destination never matches
      step(); idle(); ex_mem_ren = 1'b1; ex_wsel = 5'd0; src_reg = {5'd9, 5'd0}; #1;
      chk_out("z_a", a_out, O_NORM, M_ALL);
      chk_out("z_b", b_out, O_NORM, M_ALL);
      // Match but not a load
      step(); idle(); ex_wsel = 5'd8; src_reg = {5'd9, 5'd8}; #1;
      chk_out("nl_a", a_out, O_NORM, M_ALL);
      chk_out("nl_b", b_out, O_NORM, M_ALL);
      // Load-use on source 1
      step(); load_use(5'd9); #1;
      chk_out("s1_a", a_out, O_BUB, M_BUB);
      chk_out("s1_b", b_out, O_BUB, M_BUB);
      step(); idle(); #1;
      chk_out("s1b_a", a_out, O_BUB, M_BUB);
      chk_out("s1b_b", b_out, O_NORM, M_ALL);
      chk_stall("s1b", 16'd3, 16'd2);
      step(); idle(); #1;
      chk_out("s1c_a", a_out, O_NORM, M_ALL);
      chk_stall("s1c", 16'd4, 16'd2);

      // Data wait: 3 cycles of dhit=0, then dhit
      for (int i = 0; i < 3; i++) begin
         step(); idle(); dmem_ren = 1'b1; dhit = 1'b0; #1;
         chk_out("dw_a", a_out, O_ZERO, M_ALL);
         chk_out("dw_b", b_out, O_ZERO, M_ALL);
         if (i > 0) chk("dw_st", {14'd0, a_state}, {14'd0, DWAIT});
      end
      step(); idle(); dmem_ren = 1'b1; dhit = 1'b1; #1;
      chk_out("dh_a", a_out, O_NORM, M_ALL);
      chk_out("dh_b", b_out, O_NORM, M_ALL);
      chk("dh_st", {14'd0, b_state}, {14'd0, DWAIT});
      chk_stall("dh", 16'd7, 16'd5);
      step(); idle(); #1;
      chk("dh2_st", {14'd0, a_state}, {14'd0, RUN});
      chk_stall("dh2", 16'd7, 16'd5);

      // Redirect with ihit
      step(); idle(); redirect = 1'b1; #1;
      chk_out("rh_a", a_out, O_RH2, M_ALL);
      chk_out("rh_b", b_out, O_RH1, M_ALL);
      // Redirect arriving during LDSTALL
      step(); load_use(5'd8); #1;
      chk_out("rl1_a", a_out, O_BUB, M_BUB);
      step(); idle(); redirect = 1'b1; #1;
      chk("rl2_st", {14'd0, a_state}, {14'd0, LDSTALL});
      chk_out("rl2_a", a_out, O_RH2, M_ALL);
      chk_out("rl2_b", b_out, O_RH1, M_ALL);
      step(); idle(); #1;
      chk("rl3_st", {14'd0, a_state}, {14'd0, RUN});
      chk("rl3_ld", {14'd0, a_ld}, 16'd0);
      chk_out("rl3_a", a_out, O_NORM, M_ALL);
      chk_stall("rl3", 16'd8, 16'd6);

      // Redirect waiting on fetch for 2 cycles
      for (int i = 0; i < 2; i++) begin
         step(); idle(); redirect = 1'b1; ihit = 1'b0; #1;
         chk_out("rm_a", a_out, O_ZERO, M_ALL);
         chk_out("rm_b", b_out, O_BUB, M_BUB);
      end
      step(); idle(); redirect = 1'b1; #1;
      chk_out("rm3_a", a_out, O_RH2, M_ALL);
      chk_out("rm3_b", b_out, O_RH1, M_ALL);
      chk_stall("rm3", 16'd10, 16'd8);
      step(); idle(); #1;
      chk_out("rm4_b", b_out, O_NORM, M_ALL);

      // Fetch miss for 20 cycles: 4-bit counter saturates at 15
      for (int i = 0; i < 20; i++) begin
         step(); idle(); ihit = 1'b0; #1;
         chk_out("im_a", a_out, O_BUB, M_BUB);
         chk_out("im_b", b_out, O_BUB, M_BUB);
         chk_stall("im", 16'(10 + i), 16'((8 + i > 15) ? 15 : 8 + i));
      end
      step(); idle(); #1;
      chk_out("ime_a", a_out, O_NORM, M_ALL);
      chk_stall("ime", 16'd30, 16'd15);

      // Reset in the middle of a load-use stall
      step(); load_use(5'd8); #1;
      chk_out("xr1_a", a_out, O_BUB, M_BUB);
      step(); idle(); nrst = 1'b0; #1;
      chk_out("xr2_a", a_out, O_ZERO, M_ALL);
      chk_out("xr2_b", b_out, O_ZERO, M_ALL);
      chk_stall("xr2", 16'd31, 16'd15);
      step(); idle(); nrst = 1'b1; #1;
      chk("xr3_st", {14'd0, a_state}, {14'd0, RUN});
      chk("xr3_ld", {14'd0, a_ld}, 16'd0);
      chk_out("xr3_a", a_out, O_NORM, M_ALL);
      chk_stall("xr3", 16'd0, 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
